i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h42, 7-bit target address this block answers to.
REQ-002 clk  input  1  system clock; SCL/SDA are oversampled on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 scl_in  input  1  raw I2C SCL level from the pad.
REQ-005 sda_in  input  1  raw I2C SDA level from the pad.
REQ-006 sda_oe  output  1  1 = pull SDA low; 0 = release the line (open-drain).
REQ-007 regs_flat  output  32  register file; byte n occupies bits [8n+7:8n], n = 0..3.
REQ-008 wr_pulse  output  1  one-clk pulse when a register byte is committed.
REQ-009 wr_idx  output  2  index of the register committed; valid while wr_pulse = 1.
REQ-010 busy  output  1  1 from an addressed START (address matched) until STOP.

Function
REQ-011 scl_in and sda_in SHALL each pass through a 2-flop synchronizer, followed by a third flop for edge detection.
REQ-012 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high.
REQ-013 Bits SHALL be sampled on a synchronized SCL rising edge, MSB first.
REQ-014 sda_oe SHALL change only on a synchronized SCL falling edge, except at STOP or reset.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT.
REQ-016 Any START SHALL move to ADDR and clear the bit counter, from any state; this includes a repeated START.
REQ-017 Any STOP SHALL move to IDLE, set sda_oe = 0 and set busy = 0.
REQ-018 ADDR: shift in 8 bits (7 address bits plus R/W).
- On a match, go to ADDR_ACK and drive sda_oe = 1 for the 9th clock.
- On a mismatch, go to WAIT with sda_oe = 0.
REQ-019 After ADDR_ACK:
- R/W = 0 goes to PTR.
- R/W = 1 goes to RDATA, loading the shift register with reg[ptr].
REQ-020 PTR: the received byte's bits [1:0] SHALL be loaded into ptr; the upper bits are ignored; the block then ACKs.
REQ-021 WDATA: after 8 bits, reg[ptr] SHALL be written, together with a one-clk wr_pulse and wr_idx = ptr.
- The block then ACKs.
- ptr = ptr+1 mod 4 (wraps 3 -> 0).
REQ-022 RDATA: sda_oe SHALL equal the inverted current shift bit, updated on each SCL fall.
- After 8 bits, the line is released for the master's ACK.
- ptr increments mod 4.
REQ-023 RDATA_MACK:
- Master ACK (SDA low at SCL rise): reload from the new reg[ptr] and stay in the read loop.
- Master NACK: go to WAIT, SDA released.
REQ-024 WAIT ignores all bits and leaves only on START or STOP.
REQ-025 A START or STOP that arrives mid-byte SHALL discard the partial byte; no register write occurs.
REQ-026 ptr SHALL persist across transactions, so write-pointer-then-repeated-START-read works.
REQ-027 busy SHALL rise in the clk cycle that the address match is decided.

Reset
REQ-028 rst_n low SHALL immediately apply: state = IDLE, sda_oe = 0, regs_flat = 0, ptr = 0, wr_pulse = 0, wr_idx = 0, busy = 0, synchronizer flops = 1.
REQ-029 Reset asserted mid-transaction SHALL release SDA at once.
- After release, the block ignores the bus until the next START.

Verification
REQ-030 Write 0x84, ptr 0x01, data 0xA5, 0x3C, STOP:
- ACK on all three bytes.
- regs_flat = 32'h003CA500.
- wr_pulse seen twice, wr_idx = 1 then 2.
REQ-031 Write ptr 0x03, data 0x11, 0x22, then read 0x85 with master ACK then NACK:
- regs byte3 = 0x11, byte0 = 0x22.
- Read returns reg[1], then reg[2] (pointer wrap and persistence).
REQ-032 Address 0x50 (mismatch) write with 0xFF data:
- sda_oe stays 0 throughout.
- regs unchanged, busy stays 0.
REQ-033 Repeated START after 4 data bits of a write:
- No wr_pulse.
- The new address byte is decoded correctly.
REQ-034 Assert rst_n low while the block drives a read 0 bit:
- sda_oe = 0 in the same cycle.
- All outputs take their reset values.
REQ-035 STOP issued during RDATA:
- sda_oe = 0 within 4 clk cycles of SDA rising.
- busy = 0.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing four byte registers with auto-incrementing pointer
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] regs_flat,
    output logic        wr_pulse,
    output logic [1:0]  wr_idx,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_WAIT
    } state_t;

    // [0],[1] synchronize the pad; [2] holds the previous synchronized level
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [7:0]  sr, sr_d;
    logic        rw, rw_d;
    logic [1:0]  ptr, ptr_d;
    logic        mack, mack_d;
    logic        oe_d;
    logic [31:0] regs_d;
    logic        wr_pulse_d;
    logic [1:0]  wr_idx_d;
    logic        busy_d;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;

    // Oversample both bus lines; idle bus level is high so flops reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    assign scl_s     = scl_sync[1];
    assign scl_d     = scl_sync[2];
    assign sda_s     = sda_sync[1];
    assign sda_d     = sda_sync[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    // Byte as it will stand once the bit being sampled now is shifted in
    assign rx_byte = {sr[6:0], sda_s};
    assign rd_byte = regs_flat[{ptr, 3'b000} +: 8];

    // Protocol state and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            sr        <= 8'd0;
            rw        <= 1'b0;
            ptr       <= 2'd0;
            mack      <= 1'b0;
            sda_oe    <= 1'b0;
            regs_flat <= 32'd0;
            wr_pulse  <= 1'b0;
            wr_idx    <= 2'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sr        <= sr_d;
            rw        <= rw_d;
            ptr       <= ptr_d;
            mack      <= mack_d;
            sda_oe    <= oe_d;
            regs_flat <= regs_d;
            wr_pulse  <= wr_pulse_d;
            wr_idx    <= wr_idx_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic; ACK states drive on the first SCL fall and move on at the second
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sr_d       = sr;
        rw_d       = rw;
        ptr_d      = ptr;
        mack_d     = mack;
        oe_d       = sda_oe;
        regs_d     = regs_flat;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx;
        busy_d     = busy;

        if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d = 4'd0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            oe_d  = 1'b1;
                            cnt_d = 4'd1;
                        end else begin
                            cnt_d = 4'd0;
                            oe_d  = 1'b0;
                            if (state == ST_ADDR_ACK && rw) begin
                                sr_d    = rd_byte;
                                oe_d    = ~rd_byte[7];
                                state_d = ST_RDATA;
                            end else if (state == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d   = 4'd0;
                            ptr_d   = rx_byte[1:0];
                            state_d = ST_PTR_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d                      = 4'd0;
                            regs_d[{ptr, 3'b000} +: 8] = rx_byte;
                            wr_pulse_d                 = 1'b1;
                            wr_idx_d                   = ptr;
                            ptr_d                      = ptr + 2'd1;
                            state_d                    = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            cnt_d   = 4'd0;
                            oe_d    = 1'b0;
                            ptr_d   = ptr + 2'd1;
                            state_d = ST_RDATA_MACK;
                        end else if (cnt != 4'd0) begin
                            sr_d = {sr[6:0], 1'b0};
                            oe_d = ~sr[6];
                        end
                    end
                end
                ST_RDATA_MACK: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                        cnt_d  = 4'd1;
                    end else if (scl_fall && cnt == 4'd1) begin
                        cnt_d = 4'd0;
                        if (!mack) begin
                            sr_d    = rd_byte;
                            oe_d    = ~rd_byte[7];
                            state_d = ST_RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed I2C master with transaction-level register model
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam logic [6:0] DEV = 7'h42;
    localparam int M_IDLE = 0, M_ADDR = 1, M_PTR = 2, M_DATA = 3, M_READ = 4, M_IGN = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] regs_flat;
    logic        wr_pulse;
    logic [1:0]  wr_idx;
    logic        busy;

    logic [7:0]  m_regs [4];
    int          m_ptr;
    int          m_phase;
    logic        m_busy;
    logic        m_oe;
    int          exp_wr[$];
    int          got_wr[$];
    logic        chk_req = 1'b0;
    logic        wr_prev = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  rb0, rb1;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(DEV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .regs_flat (regs_flat),
        .wr_pulse  (wr_pulse),
        .wr_idx    (wr_idx),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_req) begin
            chk("sda_oe", 32'(sda_oe), 32'(m_oe));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("regs", regs_flat, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        end
    end

    always @(negedge clk) begin
        if (wr_pulse) begin
            got_wr.push_back(int'(wr_idx));
            chk("wr_pulse_width", 32'(wr_prev), 32'd0);
        end
        wr_prev <= wr_pulse;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_point();
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr   = 0;
        m_phase = M_IDLE;
        m_busy  = 1'b0;
        m_oe    = 1'b0;
        exp_wr.delete();
        got_wr.delete();
    endtask

    task automatic send_bit(input logic b, input logic exp_oe, output logic seen);
        scl_m = 1'b0;
        m_oe  = exp_oe;
        tick(4);
        sda_m = b;
        tick(3);
        check_point();
        scl_m = 1'b1;
        tick(4);
        seen = sda_line;
        tick(3);
    endtask

    task automatic do_start();
        scl_m = 1'b0;
        tick(4);
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b0;
        tick(6);
        m_phase = M_ADDR;
        m_oe    = 1'b0;
        check_point();
    endtask

    task automatic do_stop();
        scl_m = 1'b0;
        tick(4);
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b1;
        tick(4);
        chk("stop_sda_oe_4clk", 32'(sda_oe), 32'd0);
        chk("stop_busy_4clk", 32'(busy), 32'd0);
        m_phase = M_IDLE;
        m_oe    = 1'b0;
        m_busy  = 1'b0;
        check_point();
        chk("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk("wr_idx", 32'(got_wr[i]), 32'(exp_wr[i]));
        exp_wr.delete();
        got_wr.delete();
    endtask

    task automatic wr_byte(input logic [7:0] v);
        logic s;
        logic ack;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], 1'b0, s);
            if (i != 0) check_point();
        end
        ack = 1'b0;
        case (m_phase)
            M_ADDR: begin
                if (v[7:1] == DEV) begin
                    ack     = 1'b1;
                    m_busy  = 1'b1;
                    m_phase = v[0] ? M_READ : M_PTR;
                end else begin
                    m_phase = M_IGN;
                end
            end
            M_PTR: begin
                ack     = 1'b1;
                m_ptr   = int'(v[1:0]);
                m_phase = M_DATA;
            end
            M_DATA: begin
                ack           = 1'b1;
                m_regs[m_ptr] = v;
                exp_wr.push_back(m_ptr);
                m_ptr         = (m_ptr + 1) % 4;
            end
            default: ack = 1'b0;
        endcase
        check_point();
        send_bit(1'b1, ack, s);
        chk("ack_line", 32'(s), 32'(!ack));
        check_point();
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] got);
        logic s;
        logic [7:0] e;
        e = m_regs[m_ptr];
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, ~e[i], s);
            got[i] = s;
            check_point();
        end
        m_ptr = (m_ptr + 1) % 4;
        chk("rd_data", 32'(got), 32'(e));
        send_bit(mack ? 1'b0 : 1'b1, 1'b0, s);
        if (!mack) m_phase = M_IGN;
        check_point();
    endtask

    initial begin
        logic s;
        model_reset();
        tick(3);
        chk("reset_sda_oe", 32'(sda_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_regs", regs_flat, 32'd0);
        chk("reset_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("reset_wr_idx", 32'(wr_idx), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Write ptr 1 then two data bytes
        do_start();
        wr_byte(8'h84);
        wr_byte(8'h01);
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        chk("t1_regs", regs_flat, 32'h003CA500);
        chk("t1_wr_cnt", 32'(got_wr.size()), 32'd2);
        if (got_wr.size() == 2) begin
            chk("t1_wr_idx0", 32'(got_wr[0]), 32'd1);
            chk("t1_wr_idx1", 32'(got_wr[1]), 32'd2);
        end
        do_stop();

        // Write with pointer wrap, then repeated-START read
        do_start();
        wr_byte(8'h84);
        wr_byte(8'h03);
        wr_byte(8'h11);
        wr_byte(8'h22);
        do_start();
        wr_byte(8'h85);
        rd_byte(1'b1, rb0);
        rd_byte(1'b0, rb1);
        do_stop();
        chk("t2_regs", regs_flat, 32'h113CA522);
        chk("t2_rd0", 32'(rb0), 32'h000000A5);
        chk("t2_rd1", 32'(rb1), 32'h0000003C);

        // Address mismatch is ignored
        do_start();
        wr_byte(8'h50);
        wr_byte(8'hFF);
        do_stop();
        chk("t3_regs", regs_flat, 32'h113CA522);

        // Repeated START after four data bits
        do_start();
        wr_byte(8'h84);
        wr_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_bit(i[0] ? 1'b0 : 1'b1, 1'b0, s);
            check_point();
        end
        do_start();
        wr_byte(8'h84);
        wr_byte(8'h02);
        wr_byte(8'h77);
        chk("t4_wr_cnt", 32'(got_wr.size()), 32'd1);
        if (got_wr.size() == 1) chk("t4_wr_idx", 32'(got_wr[0]), 32'd2);
        do_stop();
        chk("t4_regs", regs_flat, 32'h1177A522);

        // STOP in the middle of a read byte
        do_start();
        wr_byte(8'h85);
        for (int i = 7; i >= 5; i--) begin
            send_bit(1'b1, ~m_regs[m_ptr][i], s);
            check_point();
        end
        do_stop();

        // Reset while driving a read 0 bit
        do_start();
        wr_byte(8'h85);
        scl_m = 1'b0;
        m_oe  = 1'b1;
        tick(7);
        check_point();
        chk("t6_drive_before_reset", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_regs", regs_flat, 32'd0);
        chk("t6_rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("t6_rst_wr_idx", 32'(wr_idx), 32'd0);
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(2);
        wr_byte(8'h85);
        do_stop();
        do_start();
        wr_byte(8'h84);
        wr_byte(8'h01);
        wr_byte(8'h99);
        do_stop();
        chk("t6_regs_after", regs_flat, 32'h00009900);

        tick(4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
